// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order tracker of in-flight branch predictions. It resolves the
// oldest branch at execute, trains the predictor and raises mispredict with a redirect PC.
//   clk, reset                 clock; synchronous active-high reset
//   predictValid/PC/T/Taken/Confidence  fetch-side enqueue of a predicted branch
//   flushIn                    discard every in-flight entry
//   exValid/exPC/exRs1/exRs2/exTarget   execute-side operands of the oldest branch
//   queueFull/queueEmpty/inFlight       occupancy
//   branchResolved/actualTaken/resolvedPC/resolvedConfidence  predictor training (registered)
//   mispredict/redirectPC      pipeline redirect (registered)
//   overflow/orderError        sticky error flags
//   resolvedCount/mispredictCount       saturating statistics
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             predictValid,
  input  logic [31:0]      predictPC,
  input  logic [2:0]       predictT,
  input  logic             predictTaken,
  input  logic [3:0]       predictConfidence,
  input  logic             flushIn,
  input  logic             exValid,
  input  logic [31:0]      exPC,
  input  logic [31:0]      exRs1,
  input  logic [31:0]      exRs2,
  input  logic [31:0]      exTarget,
  output logic             queueFull,
  output logic             queueEmpty,
  output logic [PTR_W:0]   inFlight,
  output logic             branchResolved,
  output logic             actualTaken,
  output logic [31:0]      resolvedPC,
  output logic             mispredict,
  output logic [31:0]      redirectPC,
  output logic [3:0]       resolvedConfidence,
  output logic             overflow,
  output logic             orderError,
  output logic [15:0]      resolvedCount,
  output logic [15:0]      mispredictCount
);
  logic [31:0]      pcQ   [DEPTH];
  logic [2:0]       tQ    [DEPTH];
  logic             takenQ[DEPTH];
  logic [3:0]       confQ [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;
  logic [PTR_W:0]   count;
  logic             deq, mis, enq, taken, eq, lts, ltu;
  logic [2:0]       headT;

  assign inFlight   = count;
  assign queueFull  = count == (PTR_W+1)'(DEPTH);
  assign queueEmpty = count == '0;
  assign headT      = tQ[rptr];
  assign eq         = exRs1 == exRs2;
  assign lts        = $signed(exRs1) < $signed(exRs2);
  assign ltu        = exRs1 < exRs2;

  always_comb begin
    taken = headT == 3'b000 ? eq   :
            headT == 3'b001 ? !eq  :
            headT == 3'b100 ? lts  :
            headT == 3'b101 ? !lts :
            headT == 3'b110 ? ltu  :
            headT == 3'b111 ? !ltu : 1'b0;
    deq = exValid && !queueEmpty && exPC == pcQ[rptr];
    mis = deq && taken != takenQ[rptr];
    // a mispredicting resolve makes any same-cycle fetch wrong-path; a clean pop frees a slot
    enq = predictValid && !flushIn && !mis && (!queueFull || deq);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pcQ[wptr]    <= predictPC;
      tQ[wptr]     <= predictT;
      takenQ[wptr] <= predictTaken;
      confQ[wptr]  <= predictConfidence;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr               <= '0;
      wptr               <= '0;
      count              <= '0;
      branchResolved     <= 1'b0;
      actualTaken        <= 1'b0;
      resolvedPC         <= '0;
      mispredict         <= 1'b0;
      redirectPC         <= '0;
      resolvedConfidence <= '0;
      overflow           <= 1'b0;
      orderError         <= 1'b0;
      resolvedCount      <= '0;
      mispredictCount    <= '0;
    end else if (flushIn) begin
      rptr           <= '0;
      wptr           <= '0;
      count          <= '0;
      branchResolved <= 1'b0;
      mispredict     <= 1'b0;
    end else begin
      branchResolved <= deq;
      mispredict     <= mis;
      if (deq) begin
        rptr               <= rptr + 1'b1;
        actualTaken        <= taken;
        resolvedPC         <= pcQ[rptr];
        redirectPC         <= taken ? exTarget : exPC + 32'd4;
        resolvedConfidence <= confQ[rptr];
        if (~&resolvedCount) resolvedCount <= resolvedCount + 16'd1;
      end
      if (mis && ~&mispredictCount) mispredictCount <= mispredictCount + 16'd1;
      // a mispredict drops every younger entry, so the write pointer snaps to the new head
      wptr  <= mis ? rptr + 1'b1 : enq ? wptr + 1'b1 : wptr;
      count <= mis ? '0 : count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
      if (predictValid && queueFull && !deq) overflow <= 1'b1;
      if (exValid && !deq) orderError <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;
  logic        clk = 0, reset = 0;
  logic        predictValid = 0, predictTaken = 0, flushIn = 0, exValid = 0;
  logic [31:0] predictPC = 0, exPC = 0, exRs1 = 0, exRs2 = 0, exTarget = 0;
  logic [2:0]  predictT = 0;
  logic [3:0]  predictConfidence = 0;
  logic        queueFull, queueEmpty, branchResolved, actualTaken, mispredict, overflow, orderError;
  logic [2:0]  inFlight;
  logic [31:0] resolvedPC, redirectPC;
  logic [3:0]  resolvedConfidence;
  logic [15:0] resolvedCount, mispredictCount;
  int checks = 0, errors = 0;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .predictValid(predictValid), .predictPC(predictPC),
    .predictT(predictT), .predictTaken(predictTaken), .predictConfidence(predictConfidence),
    .flushIn(flushIn), .exValid(exValid), .exPC(exPC), .exRs1(exRs1), .exRs2(exRs2),
    .exTarget(exTarget), .queueFull(queueFull), .queueEmpty(queueEmpty), .inFlight(inFlight),
    .branchResolved(branchResolved), .actualTaken(actualTaken), .resolvedPC(resolvedPC),
    .mispredict(mispredict), .redirectPC(redirectPC), .resolvedConfidence(resolvedConfidence),
    .overflow(overflow), .orderError(orderError), .resolvedCount(resolvedCount),
    .mispredictCount(mispredictCount)
  );

  always #5 clk = ~clk;

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic clr(); predictValid = 0; exValid = 0; flushIn = 0; reset = 0; endtask
  task automatic setPred(input logic [31:0] pc, input logic [2:0] t, input logic tk, input logic [3:0] cf);
    predictValid = 1; predictPC = pc; predictT = t; predictTaken = tk; predictConfidence = cf;
  endtask
  task automatic setEx(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt);
    exValid = 1; exPC = pc; exRs1 = a; exRs2 = b; exTarget = tgt;
  endtask
  task automatic enq(input logic [31:0] pc, input logic [2:0] t, input logic tk, input logic [3:0] cf);
    setPred(pc, t, tk, cf); tick(); clr();
  endtask
  task automatic exe(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt);
    setEx(pc, a, b, tgt); tick(); clr();
  endtask
  task automatic doReset(); clr(); reset = 1; tick(); clr(); endtask

  task automatic test_reset();
    doReset();
    checks++; if (queueEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", queueEmpty); end
    checks++; if (inFlight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inFlight); end
    checks++; if ({queueFull, branchResolved, actualTaken, mispredict, overflow, orderError} !== 6'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 000000", {queueFull, branchResolved, actualTaken, mispredict, overflow, orderError}); end
    checks++; if ({resolvedPC, redirectPC, resolvedConfidence, resolvedCount, mispredictCount} !== 100'b0)
      begin errors++; $display("FAIL reset_data: got %h/%h/%h/%0d/%0d want zeros", resolvedPC, redirectPC, resolvedConfidence, resolvedCount, mispredictCount); end
  endtask

  task automatic test_basic();
    enq(32'h1000, 3'b000, 1'b0, 4'd7);
    checks++; if (inFlight !== 3'd1) begin errors++; $display("FAIL basic_enq: got %0d want 1", inFlight); end
    exe(32'h1000, 32'd5, 32'd5, 32'h1040);
    checks++; if ({branchResolved, actualTaken, mispredict} !== 3'b111)
      begin errors++; $display("FAIL basic_pulse: got %b want 111", {branchResolved, actualTaken, mispredict}); end
    checks++; if (redirectPC !== 32'h1040) begin errors++; $display("FAIL basic_redirect: got %h want 00001040", redirectPC); end
    checks++; if (resolvedPC !== 32'h1000 || resolvedConfidence !== 4'd7)
      begin errors++; $display("FAIL basic_data: got %h/%0d want 00001000/7", resolvedPC, resolvedConfidence); end
    checks++; if (mispredictCount !== 16'd1 || resolvedCount !== 16'd1)
      begin errors++; $display("FAIL basic_counts: got %0d/%0d want 1/1", mispredictCount, resolvedCount); end
    checks++; if (inFlight !== 3'd0) begin errors++; $display("FAIL basic_drain: got %0d want 0", inFlight); end
    tick();
    checks++; if ({branchResolved, mispredict} !== 2'b00 || redirectPC !== 32'h1040)
      begin errors++; $display("FAIL basic_oneshot: got %b %h want 00 00001040", {branchResolved, mispredict}, redirectPC); end
  endtask

  task automatic test_full();
    doReset();
    for (int i = 0; i < 4; i++) enq(32'h1100 + 32'(4*i), 3'b000, 1'b1, 4'(i));
    checks++; if (queueFull !== 1'b1 || inFlight !== 3'd4)
      begin errors++; $display("FAIL full_state: got %b/%0d want 1/4", queueFull, inFlight); end
    enq(32'h1110, 3'b000, 1'b1, 4'd9);
    checks++; if (overflow !== 1'b1 || inFlight !== 3'd4)
      begin errors++; $display("FAIL full_overflow: got %b/%0d want 1/4", overflow, inFlight); end
    setPred(32'h1110, 3'b000, 1'b1, 4'd9); setEx(32'h1100, 32'd3, 32'd3, 32'h9000); tick(); clr();
    checks++; if (inFlight !== 3'd4 || queueFull !== 1'b1)
      begin errors++; $display("FAIL full_swap: got %0d/%b want 4/1", inFlight, queueFull); end
    checks++; if ({branchResolved, mispredict} !== 2'b10 || resolvedPC !== 32'h1100)
      begin errors++; $display("FAIL full_swap_pulse: got %b %h want 10 00001100", {branchResolved, mispredict}, resolvedPC); end
  endtask

  task automatic test_mispredict_clear();
    doReset();
    enq(32'h2000, 3'b100, 1'b1, 4'd1);
    enq(32'h2004, 3'b001, 1'b1, 4'd2);
    enq(32'h2008, 3'b000, 1'b1, 4'd3);
    exe(32'h2000, 32'hFFFF_FFFF, 32'd1, 32'h2100);
    checks++; if ({branchResolved, actualTaken, mispredict} !== 3'b110 || inFlight !== 3'd2)
      begin errors++; $display("FAIL blt_correct: got %b/%0d want 110/2", {branchResolved, actualTaken, mispredict}, inFlight); end
    setPred(32'h200C, 3'b000, 1'b1, 4'd4); setEx(32'h2004, 32'd9, 32'd9, 32'h2200); tick(); clr();
    checks++; if ({branchResolved, actualTaken, mispredict} !== 3'b101 || inFlight !== 3'd0)
      begin errors++; $display("FAIL bne_mispredict: got %b/%0d want 101/0", {branchResolved, actualTaken, mispredict}, inFlight); end
    checks++; if (redirectPC !== 32'h2008 || resolvedConfidence !== 4'd2)
      begin errors++; $display("FAIL bne_redirect: got %h/%0d want 00002008/2", redirectPC, resolvedConfidence); end
    enq(32'h2300, 3'b000, 1'b0, 4'd5);
    exe(32'h2300, 32'd1, 32'd2, 32'h2400);
    checks++; if ({branchResolved, mispredict} !== 2'b10 || resolvedPC !== 32'h2300 || inFlight !== 3'd0)
      begin errors++; $display("FAIL post_mis_ptr: got %b %h %0d want 10 00002300 0", {branchResolved, mispredict}, resolvedPC, inFlight); end
  endtask

  task automatic test_conditions();
    logic [2:0] ty [7] = '{3'b110, 3'b111, 3'b100, 3'b101, 3'b010, 3'b000, 3'b001};
    logic       ex [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] pc, want;
    for (int i = 0; i < 7; i++) begin
      pc = 32'h5000 + 32'(4*i);
      want = ex[i] ? 32'h6000 : pc + 32'd4;
      enq(pc, ty[i], 1'b0, 4'd0);
      exe(pc, 32'hFFFF_FFFF, 32'd1, 32'h6000);
      checks++; if ({branchResolved, actualTaken, mispredict} !== {1'b1, ex[i], ex[i]})
        begin errors++; $display("FAIL cond_t%b: got %b want %b", ty[i], {branchResolved, actualTaken, mispredict}, {1'b1, ex[i], ex[i]}); end
      if (ex[i]) begin
        checks++; if (redirectPC !== want) begin errors++; $display("FAIL cond_redirect_t%b: got %h want %h", ty[i], redirectPC, want); end
      end
    end
  endtask

  task automatic test_order_flush();
    doReset();
    enq(32'h3000, 3'b000, 1'b1, 4'd0);
    exe(32'h3004, 32'd0, 32'd0, 32'h0);
    checks++; if (orderError !== 1'b1 || branchResolved !== 1'b0 || inFlight !== 3'd1)
      begin errors++; $display("FAIL order_mismatch: got %b/%b/%0d want 1/0/1", orderError, branchResolved, inFlight); end
    enq(32'h3004, 3'b000, 1'b1, 4'd0);
    enq(32'h3008, 3'b000, 1'b1, 4'd0);
    checks++; if (inFlight !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d want 3", inFlight); end
    flushIn = 1; setEx(32'h3000, 32'd0, 32'd0, 32'h0); tick(); clr();
    checks++; if (queueEmpty !== 1'b1 || branchResolved !== 1'b0 || orderError !== 1'b1 || resolvedCount !== 16'd0)
      begin errors++; $display("FAIL flush: got %b/%b/%b/%0d want 1/0/1/0", queueEmpty, branchResolved, orderError, resolvedCount); end
  endtask

  task automatic test_back_to_back();
    doReset();
    enq(32'h4000, 3'b000, 1'b1, 4'd0);
    for (int i = 0; i < 10; i++) begin
      setPred(32'h4000 + 32'(4*(i+1)), 3'b000, 1'b1, 4'd0);
      setEx(32'h4000 + 32'(4*i), 32'd1, 32'd1, 32'h0);
      tick(); clr();
      checks++; if (branchResolved !== 1'b1 || resolvedPC !== 32'h4000 + 32'(4*i) || inFlight !== 3'd1)
        begin errors++; $display("FAIL b2b_%0d: got %b %h %0d want 1 %h 1", i, branchResolved, resolvedPC, inFlight, 32'h4000 + 32'(4*i)); end
    end
    checks++; if (resolvedCount !== 16'd10 || mispredictCount !== 16'd0)
      begin errors++; $display("FAIL b2b_counts: got %0d/%0d want 10/0", resolvedCount, mispredictCount); end
    enq(32'h5000, 3'b000, 1'b1, 4'd0);
    enq(32'h5004, 3'b000, 1'b1, 4'd0);
    checks++; if (inFlight !== 3'd3) begin errors++; $display("FAIL rst_pre: got %0d want 3", inFlight); end
    doReset();
    checks++; if (queueEmpty !== 1'b1 || resolvedCount !== 16'd0 || resolvedPC !== 32'h0)
      begin errors++; $display("FAIL rst_inflight: got %b/%0d/%h want 1/0/0", queueEmpty, resolvedCount, resolvedPC); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_mispredict_clear();
    test_conditions();
    test_order_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
